// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_pkg
// Shared constants for the multicycle control slice: state encodings,
// supported opcodes, ALU operation classes, mux select codes and the packed
// control vector passed from the output decoder to the top.
// ---------------------------------------------------------------------------
package multicycle_control_pkg;

  // State encodings (4-bit codes; the state register may be wider).
  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_RD    = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WR    = 4'd5;
  localparam logic [3:0] R_EXEC    = 4'd6;
  localparam logic [3:0] R_WB      = 4'd7;
  localparam logic [3:0] BRANCH    = 4'd8;
  localparam logic [3:0] ADDI_EXEC = 4'd9;
  localparam logic [3:0] ADDI_WB   = 4'd10;
  localparam logic [3:0] JUMP      = 4'd11;

  // Supported opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU decoder classes.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B-operand selects.
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] SRC_B_BOFF = 2'b11;

  // PC source selects.
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Per-state control vector produced by the output decoder.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(16'h0000);

  // True when the opcode belongs to the supported instruction set.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_checker.sv
// ---------------------------------------------------------------------------
// multicycle_control_checker
// Property checks for multicycle_control: memory read and write strobes are
// mutually exclusive at all times, and no write enable is active in reset.
//   clock, reset                   : same clock/reset as the checked block
//   mem_read, mem_write, reg_write : observed control outputs
// ---------------------------------------------------------------------------
module multicycle_control_checker (
  input logic clock,
  input logic reset,
  input logic mem_read,
  input logic mem_write,
  input logic reg_write
);

  a_mem_excl_rise: assert property (@(posedge clock) !(mem_read && mem_write));
  a_mem_excl_fall: assert property (@(negedge clock) !(mem_read && mem_write));
  a_no_write_in_reset: assert property (@(negedge clock)
                                        !reset |-> !(mem_write || reg_write || mem_read));

endmodule

// File: rtl/multicycle_control_out_decode.sv
// ---------------------------------------------------------------------------
// mc_out_decode
// Moore output decoder: maps the current state code to the datapath control
// vector. Any code outside the defined states yields an all-zero vector so a
// corrupted state register can never enable a write.
//   state : current state code (STATE_W bits)
//   ctrl  : packed control vector (pc_write, pc_write_cond, enables, selects)
// ---------------------------------------------------------------------------
module mc_out_decode
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  output ctrl_t              ctrl
);

  // Per-state control decode; unlisted fields stay at zero.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      STATE_W'(FETCH): begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      STATE_W'(DECODE): begin
        // Branch target is precomputed here, before the opcode is known.
        ctrl.alu_src_b = SRC_B_BOFF;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      STATE_W'(MEM_ADDR): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      STATE_W'(MEM_RD): begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      STATE_W'(MEM_WB): begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      STATE_W'(MEM_WR): begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      STATE_W'(R_EXEC): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      STATE_W'(R_WB): begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      STATE_W'(BRANCH): begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      STATE_W'(ADDI_EXEC): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      STATE_W'(ADDI_WB): begin
        ctrl.reg_write = 1'b1;
      end
      STATE_W'(JUMP): begin
        ctrl.pc_source = PC_SRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: begin
        ctrl = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Control FSM for a multicycle MIPS-style datapath. Holds the state register
// and next-state logic; per-state outputs come from mc_out_decode.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   op, zero            : instruction opcode and ALU zero flag
//   pc_en               : pc_write | (pc_write_cond & zero)
//   ir_write .. alu_src_a, alu_src_b, alu_op, pc_source : datapath controls
//   state               : current state (debug)
//   illegal_op          : pulse in DECODE for an unsupported opcode
// While reset is low every output is forced to zero, so the FETCH decode
// seen from the asynchronously cleared state register never leaks out.
// ---------------------------------------------------------------------------
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  output logic               pc_en,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [STATE_W-1:0] state,
  output logic               illegal_op
);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] next_state_s;
  logic               illegal_s;
  ctrl_t              ctrl_s;

  mc_out_decode #(.STATE_W(STATE_W)) u_out_decode (
    .state (state_r),
    .ctrl  (ctrl_s)
  );

  // Next-state selection; unknown codes and unsupported opcodes return to FETCH.
  always_comb begin
    next_state_s = STATE_W'(FETCH);
    illegal_s    = 1'b0;
    case (state_r)
      STATE_W'(FETCH):     next_state_s = STATE_W'(DECODE);
      STATE_W'(DECODE): begin
        case (op)
          OP_LW, OP_SW: next_state_s = STATE_W'(MEM_ADDR);
          OP_RTYPE:     next_state_s = STATE_W'(R_EXEC);
          OP_BEQ:       next_state_s = STATE_W'(BRANCH);
          OP_ADDI:      next_state_s = STATE_W'(ADDI_EXEC);
          OP_J:         next_state_s = STATE_W'(JUMP);
          default:      next_state_s = STATE_W'(FETCH);
        endcase
        illegal_s = ~op_supported(op);
      end
      STATE_W'(MEM_ADDR): begin
        // op is re-sampled here; anything other than lw/sw abandons the access.
        if (op == OP_LW) begin
          next_state_s = STATE_W'(MEM_RD);
        end else if (op == OP_SW) begin
          next_state_s = STATE_W'(MEM_WR);
        end else begin
          next_state_s = STATE_W'(FETCH);
        end
      end
      STATE_W'(MEM_RD):    next_state_s = STATE_W'(MEM_WB);
      STATE_W'(R_EXEC):    next_state_s = STATE_W'(R_WB);
      STATE_W'(ADDI_EXEC): next_state_s = STATE_W'(ADDI_WB);
      default:             next_state_s = STATE_W'(FETCH);
    endcase
  end

  // State register with asynchronous return to FETCH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= STATE_W'(FETCH);
    end else begin
      state_r <= next_state_s;
    end
  end

  // Output drive, masked to all-zero while reset is asserted.
  always_comb begin
    if (!reset) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_source  = 2'b00;
      illegal_op = 1'b0;
    end else begin
      pc_en      = ctrl_s.pc_write | (ctrl_s.pc_write_cond & zero);
      ir_write   = ctrl_s.ir_write;
      mem_read   = ctrl_s.mem_read;
      mem_write  = ctrl_s.mem_write;
      i_or_d     = ctrl_s.i_or_d;
      reg_write  = ctrl_s.reg_write;
      reg_dst    = ctrl_s.reg_dst;
      mem_to_reg = ctrl_s.mem_to_reg;
      alu_src_a  = ctrl_s.alu_src_a;
      alu_src_b  = ctrl_s.alu_src_b;
      alu_op     = ctrl_s.alu_op;
      pc_source  = ctrl_s.pc_source;
      illegal_op = illegal_s;
    end
  end

  assign state = state_r;

endmodule
